// File: rtl/reg_bank_pn_pkg.sv
// reg_bank_pn shared definitions: opcode values and state encodings.
// Ports: none (package with RegBankPN_ macros mirrored as typed constants).
`ifndef REG_BANK_PN_DEFINES
`define REG_BANK_PN_DEFINES
`define RegBankPN_OP_NOP    4'h0
`define RegBankPN_OP_LD     4'h1
`define RegBankPN_OP_CLR    4'h2
`define RegBankPN_OP_INC    4'h3
`define RegBankPN_OP_DEC    4'h4
`define RegBankPN_OP_MOV    4'h5
`define RegBankPN_OP_CLRALL 4'h6
`define RegBankPN_OP_SWAP   4'h7
`define RegBankPN_ST_RESET  2'h0
`define RegBankPN_ST_READY  2'h1
`define RegBankPN_ST_ERROR  2'h2
`endif

package reg_bank_pn_pkg;

  typedef enum logic [1:0] {
    ST_RESET = `RegBankPN_ST_RESET,
    ST_READY = `RegBankPN_ST_READY,
    ST_ERROR = `RegBankPN_ST_ERROR
  } state_e;

  localparam logic [3:0] OP_NOP    = `RegBankPN_OP_NOP;
  localparam logic [3:0] OP_LD     = `RegBankPN_OP_LD;
  localparam logic [3:0] OP_CLR    = `RegBankPN_OP_CLR;
  localparam logic [3:0] OP_INC    = `RegBankPN_OP_INC;
  localparam logic [3:0] OP_DEC    = `RegBankPN_OP_DEC;
  localparam logic [3:0] OP_MOV    = `RegBankPN_OP_MOV;
  localparam logic [3:0] OP_CLRALL = `RegBankPN_OP_CLRALL;
  localparam logic [3:0] OP_SWAP   = `RegBankPN_OP_SWAP;

endpackage

// File: rtl/reg_bank_pn_alu.sv
// reg_bank_pn_alu: combinational increment/decrement modulo 2^DataWidth.
// Ports: a (operand), dec (1 = subtract one), y (result).
module reg_bank_pn_alu #(
  parameter int DataWidth = 8
) (
  input  logic [DataWidth-1:0] a,
  input  logic                 dec,
  output logic [DataWidth-1:0] y
);

  always_comb begin
    y = dec ? a - DataWidth'(1) : a + DataWidth'(1);
  end

endmodule

// File: rtl/reg_bank_pn.sv
// reg_bank_pn: small register bank driven by a one-cycle instruction stream.
// Ports: clock, reset (async high), inst/inst_en in; out, ready, error out.
module reg_bank_pn
  import reg_bank_pn_pkg::*;
#(
  parameter  int DataWidth = 8,
  parameter  int RegCount  = 4,
  localparam int AddrWidth = $clog2(RegCount),
  localparam int InstWidth = 4 + AddrWidth + DataWidth
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [InstWidth-1:0]          inst,
  input  logic                          inst_en,
  output logic [RegCount*DataWidth-1:0] out,
  output logic                          ready,
  output logic                          error
);

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   error_q, error_d;

  logic [DataWidth-1:0] regs_q [RegCount];
  logic [DataWidth-1:0] regs_d [RegCount];

  logic [3:0]           op;
  logic [AddrWidth-1:0] dst;
  logic [AddrWidth-1:0] src;
  logic [DataWidth-1:0] imm;
  logic [DataWidth-1:0] alu_y;

  assign op  = inst[InstWidth-1 -: 4];
  assign dst = inst[DataWidth +: AddrWidth];
  assign imm = inst[DataWidth-1:0];
  // Source register index reuses the low bits of imm.
  assign src = imm[AddrWidth-1:0];

  reg_bank_pn_alu #(
    .DataWidth(DataWidth)
  ) u_alu (
    .a  (regs_q[dst]),
    .dec(op == OP_DEC),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_READY;
        regs_d  = '{default: '0};
      end
      ST_READY: begin
        if (inst_en) begin
          case (op)
            OP_NOP:    ;
            OP_LD:     regs_d[dst] = imm;
            OP_CLR:    regs_d[dst] = '0;
            OP_INC,
            OP_DEC:    regs_d[dst] = alu_y;
            OP_MOV:    regs_d[dst] = regs_q[src];
            OP_CLRALL: regs_d = '{default: '0};
            // Both writes read pre-edge values, so the swap is atomic.
            OP_SWAP: begin
              regs_d[dst] = regs_q[src];
              regs_d[src] = regs_q[dst];
            end
            default: begin
              state_d = ST_ERROR;
              regs_d  = '{default: '0};
            end
          endcase
        end
      end
      ST_ERROR: regs_d = '{default: '0};
      default: begin
        state_d = ST_ERROR;
        regs_d  = '{default: '0};
      end
    endcase
    ready_d = (state_d == ST_READY);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      regs_q  <= '{default: '0};
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  for (genvar k = 0; k < RegCount; k++) begin : g_out
    assign out[k*DataWidth +: DataWidth] = regs_q[k];
  end

  assign ready = ready_q;
  assign error = error_q;

endmodule

// File: tb/tb_reg_bank_pn.sv
// tb_reg_bank_pn: directed checks of reg_bank_pn at default and 16x8 sizes.
// Ports: none; prints a text trace of accepted instructions.
module tb_reg_bank_pn;
  import reg_bank_pn_pkg::*;

  logic        clk;
  logic        rst;
  logic [13:0] inst_a;
  logic        en_a;
  logic [31:0] out_a;
  logic        ready_a;
  logic        error_a;
  logic [22:0] inst_b;
  logic        en_b;
  logic [127:0] out_b;
  logic        ready_b;
  logic        error_b;

  int n_cmp = 0;
  int n_bad = 0;

  reg_bank_pn u_dut_a (
    .clock  (clk),
    .reset  (rst),
    .inst   (inst_a),
    .inst_en(en_a),
    .out    (out_a),
    .ready  (ready_a),
    .error  (error_a)
  );

  reg_bank_pn #(
    .DataWidth(16),
    .RegCount (8)
  ) u_dut_b (
    .clock  (clk),
    .reset  (rst),
    .inst   (inst_b),
    .inst_en(en_b),
    .out    (out_b),
    .ready  (ready_b),
    .error  (error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] mk_a(
    input logic [3:0] op, input logic [1:0] d, input logic [7:0] i);
    return {op, d, i};
  endfunction

  function automatic logic [22:0] mk_b(
    input logic [3:0] op, input logic [2:0] d, input logic [15:0] i);
    return {op, d, i};
  endfunction

  function automatic string mnem(input logic [3:0] op);
    case (op)
      OP_NOP:    return "NOP";
      OP_LD:     return "LD";
      OP_CLR:    return "CLR";
      OP_INC:    return "INC";
      OP_DEC:    return "DEC";
      OP_MOV:    return "MOV";
      OP_CLRALL: return "CLRALL";
      OP_SWAP:   return "SWAP";
      default:   return "ILLEGAL";
    endcase
  endfunction

  always @(posedge clk) begin
    if (en_a && !rst)
      $display("trace A: %s dst=%0d imm=%h rdy=%b err=%b regs=%h",
               mnem(inst_a[13:10]), inst_a[9:8], inst_a[7:0],
               ready_a, error_a, out_a);
    if (en_b && !rst)
      $display("trace B: %s dst=%0d imm=%h rdy=%b err=%b regs=%h",
               mnem(inst_b[22:19]), inst_b[18:16], inst_b[15:0],
               ready_b, error_b, out_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_a(input logic [13:0] i);
    inst_a = i;
    en_a   = 1'b1;
    step();
    en_a   = 1'b0;
    inst_a = '0;
  endtask

  task automatic do_b(input logic [22:0] i);
    inst_b = i;
    en_b   = 1'b1;
    step();
    en_b   = 1'b0;
    inst_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_a !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out got %h want %h", out_a, 32'h0);
    end
    n_cmp++;
    if ({ready_a, error_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 00", {ready_a, error_a});
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({ready_a, error_a} !== 2'b10) begin
      n_bad++;
      $display("FAIL ready_after_reset got %b want 10",
               {ready_a, error_a});
    end
  endtask

  task automatic test_ld();
    do_a(mk_a(OP_LD, 2'd2, 8'hA5));
    n_cmp++;
    if (out_a !== 32'h00A50000) begin
      n_bad++;
      $display("FAIL ld_reg2 got %h want %h", out_a, 32'h00A50000);
    end
    n_cmp++;
    if ({ready_a, error_a} !== 2'b10) begin
      n_bad++;
      $display("FAIL ld_flags got %b want 10", {ready_a, error_a});
    end
  endtask

  task automatic test_inc_dec();
    do_a(mk_a(OP_LD, 2'd1, 8'hFF));
    n_cmp++;
    if (out_a !== 32'h00A5FF00) begin
      n_bad++;
      $display("FAIL ld_reg1 got %h want %h", out_a, 32'h00A5FF00);
    end
    do_a(mk_a(OP_INC, 2'd1, 8'h00));
    n_cmp++;
    if (out_a !== 32'h00A50000) begin
      n_bad++;
      $display("FAIL inc_wrap got %h want %h", out_a, 32'h00A50000);
    end
    do_a(mk_a(OP_DEC, 2'd1, 8'h00));
    n_cmp++;
    if (out_a !== 32'h00A5FF00) begin
      n_bad++;
      $display("FAIL dec_wrap got %h want %h", out_a, 32'h00A5FF00);
    end
  endtask

  task automatic test_swap_mov();
    do_a(mk_a(OP_LD, 2'd0, 8'h12));
    do_a(mk_a(OP_LD, 2'd3, 8'h34));
    n_cmp++;
    if (out_a !== 32'h34A5FF12) begin
      n_bad++;
      $display("FAIL ld_pair got %h want %h", out_a, 32'h34A5FF12);
    end
    do_a(mk_a(OP_SWAP, 2'd0, 8'h03));
    n_cmp++;
    if (out_a !== 32'h12A5FF34) begin
      n_bad++;
      $display("FAIL swap got %h want %h", out_a, 32'h12A5FF34);
    end
    do_a(mk_a(OP_MOV, 2'd1, 8'h00));
    n_cmp++;
    if (out_a !== 32'h12A53434) begin
      n_bad++;
      $display("FAIL mov got %h want %h", out_a, 32'h12A53434);
    end
    do_a(mk_a(OP_MOV, 2'd3, 8'hFE));
    n_cmp++;
    if (out_a !== 32'hA5A53434) begin
      n_bad++;
      $display("FAIL mov_upper_imm got %h want %h", out_a, 32'hA5A53434);
    end
    do_a(mk_a(OP_CLR, 2'd2, 8'hFF));
    n_cmp++;
    if (out_a !== 32'hA5003434) begin
      n_bad++;
      $display("FAIL clr got %h want %h", out_a, 32'hA5003434);
    end
    do_a(mk_a(OP_SWAP, 2'd0, 8'h00));
    do_a(mk_a(OP_NOP, 2'd1, 8'h77));
    n_cmp++;
    if (out_a !== 32'hA5003434) begin
      n_bad++;
      $display("FAIL swap_self_nop got %h want %h", out_a, 32'hA5003434);
    end
    inst_a = mk_a(OP_LD, 2'd1, 8'h99);
    en_a   = 1'b0;
    repeat (3) step();
    inst_a = '0;
    n_cmp++;
    if (out_a !== 32'hA5003434) begin
      n_bad++;
      $display("FAIL idle_hold got %h want %h", out_a, 32'hA5003434);
    end
    do_a(mk_a(OP_CLRALL, 2'd2, 8'h55));
    n_cmp++;
    if (out_a !== 32'h0) begin
      n_bad++;
      $display("FAIL clrall got %h want %h", out_a, 32'h0);
    end
  endtask

  task automatic test_error();
    do_a(mk_a(OP_LD, 2'd0, 8'h55));
    n_cmp++;
    if (out_a !== 32'h00000055) begin
      n_bad++;
      $display("FAIL pre_err_ld got %h want %h", out_a, 32'h55);
    end
    do_a(mk_a(4'hB, 2'd1, 8'h11));
    n_cmp++;
    if ({ready_a, error_a, out_a} !== {2'b01, 32'h0}) begin
      n_bad++;
      $display("FAIL err_enter got rdy=%b err=%b out=%h want 0 1 0",
               ready_a, error_a, out_a);
    end
    do_a(mk_a(OP_LD, 2'd2, 8'hC3));
    do_a(mk_a(OP_LD, 2'd0, 8'h3C));
    n_cmp++;
    if ({ready_a, error_a, out_a} !== {2'b01, 32'h0}) begin
      n_bad++;
      $display("FAIL err_sticky got rdy=%b err=%b out=%h want 0 1 0",
               ready_a, error_a, out_a);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ready_a, error_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL err_reset got %b want 00", {ready_a, error_a});
    end
    step();
    rst = 1'b0;
    step();
    do_a(mk_a(OP_LD, 2'd2, 8'h77));
    inst_a = mk_a(OP_INC, 2'd2, 8'h00);
    en_a   = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (out_a !== 32'h007A0000) begin
      n_bad++;
      $display("FAIL inc_burst got %h want %h", out_a, 32'h007A0000);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ready_a, error_a, out_a} !== {2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL async_rst got rdy=%b err=%b out=%h want 0 0 0",
               ready_a, error_a, out_a);
    end
    step();
    rst    = 1'b0;
    inst_a = mk_a(OP_LD, 2'd0, 8'h99);
    step();
    n_cmp++;
    if ({ready_a, out_a} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL first_edge got rdy=%b out=%h want 1 0",
               ready_a, out_a);
    end
    step();
    en_a   = 1'b0;
    inst_a = '0;
    n_cmp++;
    if (out_a !== 32'h00000099) begin
      n_bad++;
      $display("FAIL second_edge got %h want %h", out_a, 32'h99);
    end
  endtask

  task automatic test_wide();
    n_cmp++;
    if ({ready_b, error_b, out_b} !== {2'b10, 128'h0}) begin
      n_bad++;
      $display("FAIL wide_idle got rdy=%b err=%b out=%h",
               ready_b, error_b, out_b);
    end
    do_b(mk_b(OP_LD, 3'd7, 16'hBEEF));
    n_cmp++;
    if (out_b !== {16'hBEEF, 112'h0}) begin
      n_bad++;
      $display("FAIL wide_ld7 got %h want %h", out_b, {16'hBEEF, 112'h0});
    end
    do_b(mk_b(OP_CLRALL, 3'd1, 16'h1234));
    n_cmp++;
    if (out_b !== 128'h0) begin
      n_bad++;
      $display("FAIL wide_clrall got %h want 0", out_b);
    end
    do_b(mk_b(OP_LD, 3'd3, 16'hFFFF));
    do_b(mk_b(OP_INC, 3'd3, 16'h0000));
    do_b(mk_b(OP_LD, 3'd5, 16'hCAFE));
    n_cmp++;
    if (out_b !== {32'h0, 16'hCAFE, 80'h0}) begin
      n_bad++;
      $display("FAIL wide_inc_ld got %h want %h",
               out_b, {32'h0, 16'hCAFE, 80'h0});
    end
    inst_b = mk_b(OP_CLR, 3'd5, 16'h0);
    en_b   = 1'b0;
    repeat (10) step();
    inst_b = '0;
    n_cmp++;
    if ({ready_b, out_b} !== {1'b1, 32'h0, 16'hCAFE, 80'h0}) begin
      n_bad++;
      $display("FAIL wide_hold got rdy=%b out=%h", ready_b, out_b);
    end
  endtask

  initial begin
    rst    = 1'b0;
    en_a   = 1'b0;
    inst_a = '0;
    en_b   = 1'b0;
    inst_b = '0;
    #1;
    test_reset();
    test_ld();
    test_inc_dec();
    test_swap_mov();
    test_error();
    test_async_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
